// File: rtl/alu_pkg.sv
// Opcode and FSM state encodings shared by the sequential ALU and its bench.
// Latency: none (definitions only); backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    function automatic logic op_inverts_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational WIDTH-bit adder with optional b inversion and carry-in.
// Latency: 0 cycles; backpressure: none.
module alu_addsub_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_inv_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_full;

    assign w_b    = i_inv_b ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];
    // Overflow is judged against the effective (possibly inverted) b operand.
    assign o_ovf  = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-edge add/sub/logic ops, iterative shift-add MUL, registered flags.
// Latency: 1 edge (non-MUL), WIDTH edges (MUL); start is ignored while busy, no queuing.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_flag_c,
    output logic             o_flag_v,
    output logic             o_flag_z,
    output logic             o_flag_n,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 2);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_done;

    logic             w_in_mul;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_inv_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_pp0;
    logic [WIDTH-1:0] w_hi_add;
    logic             w_c_add;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_in_mul = (r_state == ST_MUL);

    // The adder is shared: operand path in IDLE, accumulate path while multiplying.
    assign w_add_a = w_in_mul ? r_hi    : i_a;
    assign w_add_b = w_in_mul ? r_mcand : i_b;
    assign w_inv_b = !w_in_mul && op_inverts_b(i_op);

    always_comb begin
        w_cin = 1'b0;
        if (!w_in_mul) begin
            case (i_op)
                OP_SUB:         w_cin = 1'b1;
                OP_ADC, OP_SBC: w_cin = r_flag_c;
                default:        w_cin = 1'b0;
            endcase
        end
    end

    alu_addsub_core #(.WIDTH(WIDTH)) u_addsub (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .i_inv_b (w_inv_b),
        .i_cin   (w_cin),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_ovf   (w_ovf)
    );

    always_comb begin
        w_logic = '0;
        case (i_op)
            OP_AND:  w_logic = i_a & i_b;
            OP_OR:   w_logic = i_a | i_b;
            OP_XOR:  w_logic = i_a ^ i_b;
            default: w_logic = '0;
        endcase
    end

    assign w_res = i_op[2] ? w_logic : w_sum;

    // Product register {r_hi, r_lo} shifts right one bit per step; multiplier bit 0
    // is consumed on the accepting edge so WIDTH bits fit in WIDTH-1 busy cycles.
    assign w_pp0    = i_a & {WIDTH{i_b[0]}};
    assign w_hi_add = r_lo[0] ? w_sum : r_hi;
    assign w_c_add  = r_lo[0] & w_cout;
    assign w_hi_nxt = {w_c_add, w_hi_add[WIDTH-1:1]};
    assign w_lo_nxt = {w_hi_add[0], r_lo[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_mcand     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_start) begin
                    if (i_op == OP_MUL) begin
                        r_mcand <= i_a;
                        r_hi    <= {1'b0, w_pp0[WIDTH-1:1]};
                        r_lo    <= {w_pp0[0], i_b[WIDTH-1:1]};
                        r_cnt   <= '0;
                        r_state <= ST_MUL;
                    end else begin
                        r_result    <= w_res;
                        r_result_hi <= '0;
                        r_flag_c    <= i_op[2] ? 1'b0 : w_cout;
                        r_flag_v    <= i_op[2] ? 1'b0 : w_ovf;
                        r_flag_z    <= (w_res == '0);
                        r_flag_n    <= w_res[WIDTH-1];
                        r_done      <= 1'b1;
                    end
                end
            end else begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST_STEP) begin
                    r_result    <= w_lo_nxt;
                    r_result_hi <= w_hi_nxt;
                    r_flag_c    <= |w_hi_nxt;
                    r_flag_v    <= 1'b0;
                    r_flag_z    <= (w_lo_nxt == '0);
                    r_flag_n    <= w_lo_nxt[WIDTH-1];
                    r_done      <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            end
        end
    end

    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;
    assign o_flag_c    = r_flag_c;
    assign o_flag_v    = r_flag_v;
    assign o_flag_z    = r_flag_z;
    assign o_flag_n    = r_flag_n;
    assign o_busy      = w_in_mul;
    assign o_done      = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal checks plus randomized traffic against a cycle-level model.
module tb_alu_seq;

    localparam int W = 16;
    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint HALF = longint'(1) << (W - 1);

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    logic [W-1:0] result, result_hi;
    logic         flag_c, flag_v, flag_z, flag_n, busy, done;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_op        (op),
        .i_a         (a),
        .i_b         (b),
        .o_result    (result),
        .o_result_hi (result_hi),
        .o_flag_c    (flag_c),
        .o_flag_v    (flag_v),
        .o_flag_z    (flag_z),
        .o_flag_n    (flag_n),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } alu_out_t;

    // Plain integer arithmetic: unsigned sum for carry, signed sum for overflow.
    function automatic alu_out_t model_alu(input logic [2:0] f, input longint x,
                                           input longint y, input logic cf);
        alu_out_t o;
        longint yy, cin, u, sx, sy, s;
        o = '0;
        case (f)
            3'd4: o.res = W'(x & y);
            3'd5: o.res = W'(x | y);
            3'd6: o.res = W'(x ^ y);
            default: begin
                yy  = (f == 3'd1 || f == 3'd3) ? (~y & MASK) : y;
                cin = (f == 3'd0) ? 0 : (f == 3'd1) ? 1 : longint'(cf);
                u   = x + yy + cin;
                o.res = W'(u & MASK);
                o.c   = (u >> W) != 0;
                sx  = (x >= HALF) ? x - (HALF * 2) : x;
                sy  = (yy >= HALF) ? yy - (HALF * 2) : yy;
                s   = sx + sy + cin;
                o.v = (s > HALF - 1) || (s < -HALF);
            end
        endcase
        return o;
    endfunction

    logic [W-1:0] m_res = '0, m_hi = '0;
    logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0, m_done = 1'b0;
    int           m_left = 0;
    longint       m_prod = 0;

    // Model: a MUL simply occupies the unit for W-1 cycles, then publishes a*b.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res <= '0; m_hi <= '0; m_c <= 1'b0; m_v <= 1'b0;
            m_z <= 1'b0; m_n <= 1'b0; m_done <= 1'b0; m_left <= 0; m_prod <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res  <= W'(m_prod & MASK);
                    m_hi   <= W'(m_prod >> W);
                    m_c    <= (m_prod >> W) != 0;
                    m_v    <= 1'b0;
                    m_z    <= (m_prod & MASK) == 0;
                    m_n    <= m_prod[W-1];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op == 3'd7) begin
                    m_left <= W - 1;
                    m_prod <= longint'(a) * longint'(b);
                end else begin
                    m_res  <= model_alu(op, longint'(a), longint'(b), m_c).res;
                    m_hi   <= '0;
                    m_c    <= model_alu(op, longint'(a), longint'(b), m_c).c;
                    m_v    <= model_alu(op, longint'(a), longint'(b), m_c).v;
                    m_z    <= model_alu(op, longint'(a), longint'(b), m_c).res == '0;
                    m_n    <= model_alu(op, longint'(a), longint'(b), m_c).res[W-1];
                    m_done <= 1'b1;
                end
            end
        end
    end

    logic [2*W+5:0] cmp_got, cmp_exp;
    assign cmp_got = {result, result_hi, flag_c, flag_v, flag_z, flag_n, busy, done};
    assign cmp_exp = {m_res, m_hi, m_c, m_v, m_z, m_n, (m_left > 0), m_done};

    always @(negedge clk) begin
        tests++;
        if (cmp_got !== cmp_exp) begin
            fails++;
            $display("FAIL cycle_compare t=%0t got={res,hi,cvzn,busy,done}=%h expected=%h",
                     $time, cmp_got, cmp_exp);
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #1;
        start = 1'b1; op = f; a = x; b = y;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            fails++;
            $display("FAIL wait_done_timeout got busy=%0b expected=0", busy);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return W'(HALF);
            3:       return W'(HALF - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_result", longint'(result), 0);
        chk("reset_flags_busy_done", longint'({flag_c, flag_v, flag_z, flag_n, busy, done}), 0);
        #2 rst_n = 1'b1;

        issue(3'd0, 16'h0A0A, 16'hB0B0);
        idle();
        @(negedge clk);
        chk("add_result", longint'(result), 64'hBABA);
        chk("add_cvzn", longint'({flag_c, flag_v, flag_z, flag_n}), 4'b0001);
        chk("add_done", longint'(done), 1);
        @(negedge clk);
        chk("add_done_one_cycle", longint'(done), 0);

        issue(3'd1, 16'h8888, 16'h1111);
        idle();
        @(negedge clk);
        chk("sub_result", longint'(result), 64'h7777);
        chk("sub_cvzn", longint'({flag_c, flag_v, flag_z, flag_n}), 4'b1100);

        issue(3'd0, 16'hFFFF, 16'h0001);
        issue(3'd2, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("add_wrap_result", longint'(result), 0);
        chk("add_wrap_c_z", longint'({flag_c, flag_z}), 2'b11);
        idle();
        @(negedge clk);
        chk("adc_result", longint'(result), 1);
        chk("adc_c_z", longint'({flag_c, flag_z, done}), 3'b001);

        issue(3'd7, 16'h0123, 16'h0100);
        idle();
        wait_done(n);
        chk("mul_busy_cycles", longint'(n), 15);
        chk("mul_done", longint'(done), 1);
        chk("mul_result", longint'(result), 64'h2300);
        chk("mul_result_hi", longint'(result_hi), 1);
        chk("mul_c", longint'(flag_c), 1);

        issue(3'd7, 16'h0003, 16'h0005);
        idle();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("mul_ignore_start_result", longint'(result), 64'h000F);
        chk("mul_ignore_start_hi_c", longint'({result_hi, flag_c}), 0);

        issue(3'd7, 16'h1234, 16'hFFFF);
        idle();
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midmul_reset_result", longint'({result, result_hi}), 0);
        chk("midmul_reset_flags_busy", longint'({flag_c, flag_v, flag_z, flag_n, busy, done}), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk) chk("no_done_after_reset", longint'(done), 0);

        issue(3'd0, 16'h0001, 16'h0001);
        idle();
        @(negedge clk);
        chk("post_reset_add", longint'({result, done}), longint'({16'h0002, 1'b1}));

        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 9) < 6);
            op    = 3'($urandom_range(0, 7));
            a     = pick();
            b     = pick();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU that generalises the 16-bit add/subtract ALU to WIDTH bits. It adds carry-chained ADC/SBC, bitwise logic and an iterative shift-add multiplier, and registers result and flags behind a start/busy/done handshake. It sits between the register file read ports and the write-back stage of the RISC datapath. Condition flags persist until the next completed operation.

## Interface
- WIDTH, 16, operand/result width (≥4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only when busy=0.
- op  in  3  opcode.
  - 000 ADD, 001 SUB, 010 ADC, 011 SBC.
  - 100 AND, 101 OR, 110 XOR, 111 MUL.
- a, b  in  WIDTH  operands; sampled on the accepting edge.
- result  out  WIDTH  registered result (low half for MUL).
- result_hi  out  WIDTH  MUL high half; 0 after any non-MUL op.
- flag_c, flag_v, flag_z, flag_n  out  1  registered carry, overflow, zero and negative flags.
- busy  out  1  high while MUL iterates.
- done  out  1  one-cycle pulse when result and flags update.

## Operation
- FSM states: IDLE, MUL.
- IDLE with start=1 and op≠MUL:
  - Compute combinationally.
  - On the same edge, write result, flags and done=1.
  - Stay in IDLE.
- IDLE with start=1 and op=MUL:
  - Latch a as multiplicand and b as multiplier.
  - Clear the 2·WIDTH accumulator and the counter; set busy=1; go to MUL.
- MUL: each edge adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
- When counter reaches WIDTH−1, that edge:
  - writes the final product to result/result_hi;
  - updates flags;
  - sets done=1 and busy=0;
  - returns to IDLE.
- Arithmetic uses a WIDTH+1-bit sum.
  - ADD: a+b. SUB: a+~b+1.
  - ADC: a+b+flag_c. SBC: a+~b+flag_c.
  - flag_c = carry out, so for SUB/SBC 1 means no borrow.
  - flag_v = signed overflow: operand signs (b inverted for SUB/SBC) are equal and the result sign differs.
- Logic ops: flag_c=0, flag_v=0.
- MUL is unsigned: flag_c = |result_hi, flag_v=0.
- For all ops: flag_z = (result==0) and flag_n = result[WIDTH−1]. For MUL these use the low half only.
- start while busy=1 is ignored; no queuing.
- Operand changes during MUL have no effect.
- Reset at any time, including mid-MUL:
  - state IDLE;
  - result, result_hi, all flags, busy, done = 0;
  - counter and accumulator cleared;
  - the in-flight MUL is discarded with no done pulse.

## Timing
- Non-MUL latency: 1 edge. done is high for exactly the cycle after the accepting edge.
- MUL latency: WIDTH edges from the accepting edge to the done edge. busy is high for WIDTH−1 cycles, then deasserts as done pulses.
- A new start is accepted in the done cycle, since busy=0 there. Back-to-back non-MUL ops sustain one per cycle.
- ADC/SBC read flag_c as registered before the accepting edge. This is the previous completed op's carry, including one completing on the prior edge.
- Flags and result change only on done edges.

## Structure
- Package alu_pkg holds:
  - the op encodings as localparams/enum (OP_ADD … OP_MUL);
  - the FSM state enum (ST_IDLE, ST_MUL).
- Sub-module alu_addsub_core: combinational WIDTH-bit adder with operand inversion and carry-in. It outputs sum, carry and overflow and is reused by the MUL accumulate step.
- Top holds the FSM, operand/accumulator registers, counter (clog2(WIDTH) bits) and flag registers.

## Test plan
- WIDTH=16, ADD 0x0A0A+0xB0B0 → result 0xBABA; C=0, V=0, Z=0, N=1; done one cycle.
- SUB 0x8888−0x1111 → 0x7777; C=1, V=1, Z=0, N=0.
- ADD 0xFFFF+0x0001 → 0x0000 with C=1, Z=1. Next cycle ADC 0x0000+0x0000 → 0x0001 with C=0, Z=0.
- MUL 0x0123×0x0100 → result 0x2300, result_hi 0x0001, C=1; busy high 15 cycles, done on the 16th edge after acceptance.
- MUL 0x0003×0x0005 with start pulsed again mid-operation using ADD → second start ignored; result 0x000F, C=0.
- rst_n low at MUL iteration 8 → all outputs 0, no done. A subsequent ADD 1+1 yields 0x0002 after one edge.
